// File: rtl/timing_leak_monitor_if.sv
// Bus bundle between the dual-multiplier timing bench (master) and timing_leak_monitor (slave).
// The master drives start/done/operands/clr_stats; the slave returns verdicts and statistics.
interface timing_leak_monitor_if #(
    parameter int CNT_W = 8,
    parameter int EVT_W = 8
);
    logic             start;
    logic             done_one;
    logic             done_two;
    logic [3:0]       secret_one;
    logic [3:0]       secret_two;
    logic             clr_stats;

    logic             busy;
    logic             result_valid;
    logic             leak;
    logic             timeout;
    logic [CNT_W-1:0] lat_one;
    logic [CNT_W-1:0] lat_two;
    logic [CNT_W-1:0] skew;
    logic [EVT_W-1:0] leak_count;
    logic             leak_sticky;
    logic [3:0]       first_leak_one;
    logic [3:0]       first_leak_two;

    modport master (
        output start, done_one, done_two, secret_one, secret_two, clr_stats,
        input  busy, result_valid, leak, timeout, lat_one, lat_two, skew,
               leak_count, leak_sticky, first_leak_one, first_leak_two
    );

    modport slave (
        input  start, done_one, done_two, secret_one, secret_two, clr_stats,
        output busy, result_valid, leak, timeout, lat_one, lat_two, skew,
               leak_count, leak_sticky, first_leak_one, first_leak_two
    );
endinterface

// File: rtl/timing_leak_monitor.sv
// Measures per-instance done latency after a shared start, reports skew/leak verdicts and saturating stats.
// Optional macro LEAK_CAPTURE_EN keeps the operands of the first leaking op since reset/clear.
module timing_leak_monitor #(
    parameter int CNT_W   = 8,
    parameter int EVT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    timing_leak_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cyc, latOneAcc, latTwoAcc;
    logic             gotOne, gotTwo;

    logic             hitOne, hitTwo, bothGot, expired, finish, leakFin;
    logic [CNT_W-1:0] latOneFin, latTwoFin, skewFin;

    logic [CNT_W-1:0] latOne, latTwo, skewReg;
    logic             leakReg, timeoutReg, leakSticky;
    logic [EVT_W-1:0] leakCount;

    // Completion and final latencies as they will be latched on the closing edge.
    always_comb begin
        hitOne    = bus.done_one && !gotOne;
        hitTwo    = bus.done_two && !gotTwo;
        bothGot   = (gotOne || hitOne) && (gotTwo || hitTwo);
        expired   = !bothGot && (cyc == CNT_W'(TIMEOUT));
        finish    = (state == MEASURE) && (bothGot || expired);
        latOneFin = (hitOne || (expired && !gotOne)) ? cyc : latOneAcc;
        latTwoFin = (hitTwo || (expired && !gotTwo)) ? cyc : latTwoAcc;
        skewFin   = (latOneFin >= latTwoFin) ? (latOneFin - latTwoFin) : (latTwoFin - latOneFin);
        leakFin   = (latOneFin != latTwoFin) || expired;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = MEASURE;
            MEASURE: if (finish)    stateNext = REPORT;
            REPORT:                 stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state == MEASURE) || (state == REPORT);
        bus.result_valid = (state == REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc        <= '0;
            latOneAcc  <= '0;
            latTwoAcc  <= '0;
            gotOne     <= 1'b0;
            gotTwo     <= 1'b0;
            latOne     <= '0;
            latTwo     <= '0;
            skewReg    <= '0;
            leakReg    <= 1'b0;
            timeoutReg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cyc    <= CNT_W'(1);
                    gotOne <= 1'b0;
                    gotTwo <= 1'b0;
                end
                MEASURE: begin
                    if (hitOne) begin
                        latOneAcc <= cyc;
                        gotOne    <= 1'b1;
                    end
                    if (hitTwo) begin
                        latTwoAcc <= cyc;
                        gotTwo    <= 1'b1;
                    end
                    if (!finish) cyc <= cyc + 1'b1;
                end
                default: ;
            endcase
            if (finish) begin
                latOne     <= latOneFin;
                latTwo     <= latTwoFin;
                skewReg    <= skewFin;
                leakReg    <= leakFin;
                timeoutReg <= expired;
            end
        end
    end

    // Clear beats a coincident leaking update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leakCount  <= '0;
            leakSticky <= 1'b0;
        end else if (bus.clr_stats) begin
            leakCount  <= '0;
            leakSticky <= 1'b0;
        end else if (finish && leakFin) begin
            if (leakCount != '1) leakCount <= leakCount + 1'b1;
            leakSticky <= 1'b1;
        end
    end

`ifdef LEAK_CAPTURE_EN
    logic [3:0] secOne, secTwo, firstOne, firstTwo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secOne <= '0;
            secTwo <= '0;
        end else if (state == IDLE && bus.start) begin
            secOne <= bus.secret_one;
            secTwo <= bus.secret_two;
        end
    end

    // leakSticky low means no leak has been seen since reset/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firstOne <= '0;
            firstTwo <= '0;
        end else if (bus.clr_stats) begin
            firstOne <= '0;
            firstTwo <= '0;
        end else if (finish && leakFin && !leakSticky) begin
            firstOne <= secOne;
            firstTwo <= secTwo;
        end
    end

    assign bus.first_leak_one = firstOne;
    assign bus.first_leak_two = firstTwo;
`else
    logic unusedSecrets;
    assign unusedSecrets      = ^{bus.secret_one, bus.secret_two};
    assign bus.first_leak_one = 4'h0;
    assign bus.first_leak_two = 4'h0;
`endif

    assign bus.lat_one     = latOne;
    assign bus.lat_two     = latTwo;
    assign bus.skew        = skewReg;
    assign bus.leak        = leakReg;
    assign bus.timeout     = timeoutReg;
    assign bus.leak_count  = leakCount;
    assign bus.leak_sticky = leakSticky;
endmodule

// File: tb/tb_timing_leak_monitor.sv
// Directed self-checking bench for timing_leak_monitor (EVT_W=2 so saturation is reachable).
module tb_timing_leak_monitor;
    localparam int CNT_W   = 8;
    localparam int EVT_W   = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    timing_leak_monitor_if #(.CNT_W(CNT_W), .EVT_W(EVT_W)) bus ();

    timing_leak_monitor #(.CNT_W(CNT_W), .EVT_W(EVT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge T; done_x pulsed so it is sampled at edge T+kx (0 = never).
    // rvAt is the spec-style cycle number (T+rvAt) of result_valid, -1 if never seen.
    task automatic runOp(input int k1, input int k2, input logic [3:0] s1, input logic [3:0] s2,
                         input bit stale, input int midStart, input int clrAt, output int rvAt);
        bus.start      = 1'b1;
        bus.secret_one = s1;
        bus.secret_two = s2;
        bus.done_one   = stale;
        bus.done_two   = stale;
        tick();
        bus.start      = 1'b0;
        bus.secret_one = 4'h0;
        bus.secret_two = 4'h0;
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
        rvAt = -1;
        for (int c = 1; c <= 100; c++) begin
            bus.done_one  = (c == k1);
            bus.done_two  = (c == k2);
            bus.start     = (c == midStart);
            bus.clr_stats = (c == clrAt);
            tick();
            if (bus.result_valid === 1'b1) begin
                rvAt = c + 1;
                break;
            end
        end
        bus.done_one  = 1'b0;
        bus.done_two  = 1'b0;
        bus.start     = 1'b0;
        bus.clr_stats = 1'b0;
    endtask

    // Called right after result_valid was seen: it must drop and the monitor go idle.
    task automatic checkPulseEnd(input string name);
        tick();
        compared++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_pulse_end: rv=%b busy=%b want 0/0", name, bus.result_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.done_one = 1'b0; bus.done_two = 1'b0;
        bus.secret_one = 4'h0; bus.secret_two = 4'h0; bus.clr_stats = 1'b0;
        rst = 1'b1;
        tick(); tick();
        compared++;
        if ({bus.busy, bus.result_valid, bus.leak, bus.timeout, bus.leak_sticky} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.busy, bus.result_valid, bus.leak, bus.timeout, bus.leak_sticky});
        end
        compared++;
        if ({bus.lat_one, bus.lat_two, bus.skew, bus.leak_count, bus.first_leak_one, bus.first_leak_two} !== '0) begin
            mismatched++;
            $display("FAIL reset_values: lat1=%0d lat2=%0d skew=%0d cnt=%0d f1=%h f2=%h want all 0",
                     bus.lat_one, bus.lat_two, bus.skew, bus.leak_count, bus.first_leak_one, bus.first_leak_two);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_equal_latency();
        int rvAt;
        runOp(5, 5, 4'h5, 4'h5, 1'b0, 0, 0, rvAt);
        compared++;
        if (rvAt !== 6) begin mismatched++; $display("FAIL equal_rv_cycle: got %0d want 6", rvAt); end
        compared++;
        if (bus.leak !== 1'b0 || bus.skew !== 8'd0 || bus.timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL equal_verdict: leak=%b skew=%0d to=%b want 0/0/0", bus.leak, bus.skew, bus.timeout);
        end
        compared++;
        if (bus.lat_one !== 8'd5 || bus.lat_two !== 8'd5 || bus.leak_count !== 2'd0) begin
            mismatched++;
            $display("FAIL equal_lat: lat1=%0d lat2=%0d cnt=%0d want 5/5/0", bus.lat_one, bus.lat_two, bus.leak_count);
        end
        checkPulseEnd("equal");
    endtask

    task automatic test_skew();
        int rvAt;
        logic [3:0] wantF1, wantF2;
`ifdef LEAK_CAPTURE_EN
        wantF1 = 4'h9; wantF2 = 4'h3;
`else
        wantF1 = 4'h0; wantF2 = 4'h0;
`endif
        runOp(4, 7, 4'h9, 4'h3, 1'b0, 0, 0, rvAt);
        compared++;
        if (rvAt !== 8) begin mismatched++; $display("FAIL skew_rv_cycle: got %0d want 8", rvAt); end
        compared++;
        if (bus.leak !== 1'b1 || bus.skew !== 8'd3 || bus.lat_one !== 8'd4 || bus.lat_two !== 8'd7) begin
            mismatched++;
            $display("FAIL skew_verdict: leak=%b skew=%0d lat1=%0d lat2=%0d want 1/3/4/7",
                     bus.leak, bus.skew, bus.lat_one, bus.lat_two);
        end
        compared++;
        if (bus.leak_count !== 2'd1 || bus.leak_sticky !== 1'b1) begin
            mismatched++;
            $display("FAIL skew_stats: cnt=%0d sticky=%b want 1/1", bus.leak_count, bus.leak_sticky);
        end
        compared++;
        if (bus.first_leak_one !== wantF1 || bus.first_leak_two !== wantF2) begin
            mismatched++;
            $display("FAIL skew_first_leak: got %h/%h want %h/%h",
                     bus.first_leak_one, bus.first_leak_two, wantF1, wantF2);
        end
        checkPulseEnd("skew");
    endtask

    task automatic test_timeout();
        int rvAt;
        runOp(2, 0, 4'h1, 4'h2, 1'b0, 0, 0, rvAt);
        compared++;
        if (rvAt !== 65) begin mismatched++; $display("FAIL timeout_rv_cycle: got %0d want 65", rvAt); end
        compared++;
        if (bus.timeout !== 1'b1 || bus.leak !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_flags: to=%b leak=%b want 1/1", bus.timeout, bus.leak);
        end
        compared++;
        if (bus.lat_one !== 8'd2 || bus.lat_two !== 8'd64 || bus.skew !== 8'd62) begin
            mismatched++;
            $display("FAIL timeout_lat: lat1=%0d lat2=%0d skew=%0d want 2/64/62", bus.lat_one, bus.lat_two, bus.skew);
        end
        compared++;
        if (bus.leak_count !== 2'd2) begin
            mismatched++;
            $display("FAIL timeout_count: got %0d want 2", bus.leak_count);
        end
        checkPulseEnd("timeout");
    endtask

    task automatic test_saturation();
        int rvAt;
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        compared++;
        if (bus.leak_count !== 2'd0 || bus.leak_sticky !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_clear: cnt=%0d sticky=%b want 0/0", bus.leak_count, bus.leak_sticky);
        end
        for (int i = 0; i < 5; i++) begin
            runOp(1, 2, 4'h0, 4'h0, 1'b0, 0, 0, rvAt);
            compared++;
            if (rvAt !== 3 || bus.leak_count !== want[i]) begin
                mismatched++;
                $display("FAIL sat_op%0d: rv_at=%0d cnt=%0d want 3/%0d", i, rvAt, bus.leak_count, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignored_inputs();
        int rvAt;
        int rvSeen;
        runOp(3, 3, 4'h0, 4'h0, 1'b1, 0, 0, rvAt);
        compared++;
        if (rvAt !== 4 || bus.lat_one !== 8'd3 || bus.lat_two !== 8'd3 || bus.leak !== 1'b0) begin
            mismatched++;
            $display("FAIL stale_done: rv_at=%0d lat1=%0d lat2=%0d leak=%b want 4/3/3/0",
                     rvAt, bus.lat_one, bus.lat_two, bus.leak);
        end
        tick();
        runOp(6, 6, 4'h0, 4'h0, 1'b0, 2, 0, rvAt);
        compared++;
        if (rvAt !== 7 || bus.lat_one !== 8'd6 || bus.lat_two !== 8'd6) begin
            mismatched++;
            $display("FAIL mid_start: rv_at=%0d lat1=%0d lat2=%0d want 7/6/6", rvAt, bus.lat_one, bus.lat_two);
        end
        tick();
        // Abort an op with reset after edge T+2; stats are non-zero beforehand.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        bus.done_one = 1'b1;
        bus.done_two = 1'b1;
        tick(); tick();
        compared++;
        if ({bus.busy, bus.result_valid, bus.leak_sticky, bus.leak_count, bus.lat_one, bus.lat_two} !== '0) begin
            mismatched++;
            $display("FAIL midop_reset: busy=%b rv=%b sticky=%b cnt=%0d lat1=%0d lat2=%0d want all 0",
                     bus.busy, bus.result_valid, bus.leak_sticky, bus.leak_count, bus.lat_one, bus.lat_two);
        end
        rst = 1'b0;
        rvSeen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.result_valid === 1'b1) rvSeen++;
        end
        bus.done_one = 1'b0;
        bus.done_two = 1'b0;
        compared++;
        if (rvSeen !== 0) begin
            mismatched++;
            $display("FAIL midop_reset_no_rv: saw %0d pulses want 0", rvSeen);
        end
    endtask

    task automatic test_clear_priority();
        int rvAt;
        runOp(1, 3, 4'hA, 4'h5, 1'b0, 0, 0, rvAt);
        compared++;
        if (bus.leak_count !== 2'd1 || bus.leak_sticky !== 1'b1) begin
            mismatched++;
            $display("FAIL clrpri_setup: cnt=%0d sticky=%b want 1/1", bus.leak_count, bus.leak_sticky);
        end
        tick();
        runOp(1, 4, 4'hC, 4'h6, 1'b0, 0, 4, rvAt);
        compared++;
        if (rvAt !== 5 || bus.leak !== 1'b1) begin
            mismatched++;
            $display("FAIL clrpri_leak: rv_at=%0d leak=%b want 5/1", rvAt, bus.leak);
        end
        compared++;
        if (bus.leak_count !== 2'd0 || bus.leak_sticky !== 1'b0 ||
            bus.first_leak_one !== 4'h0 || bus.first_leak_two !== 4'h0) begin
            mismatched++;
            $display("FAIL clrpri_stats: cnt=%0d sticky=%b f1=%h f2=%h want 0/0/0/0",
                     bus.leak_count, bus.leak_sticky, bus.first_leak_one, bus.first_leak_two);
        end
        checkPulseEnd("clrpri");
    endtask

    initial begin
        test_reset();
        test_equal_latency();
        test_skew();
        test_timeout();
        test_saturation();
        test_ignored_inputs();
        test_clear_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
